debounce_bank: RTL

- Multi-channel, parametrised push-button/switch conditioner; replaces the single-channel shift-register debouncer.
- Per channel: 2-flop synchroniser, tick-sampled stability counter, debounced level, one-clock press/release pulses, one-shot long-press pulse.
- All channels share one tick prescaler.
- Sits between board pins and control logic (PWM/servo mode select, jog buttons).

---
 rtl/debounce_bank_pkg.sv | 24 ++
 rtl/debounce_bank_if.sv | 12 +
 rtl/debounce_bank_tick_gen.sv | 25 ++
 rtl/debounce_bank.sv | 103 ++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// Shared constants and helpers for the debounce bank: tick divider, counter widths,
// and the raw pin level that means "released".
package debounce_bank_pkg;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_CLK_HZ       = 50000000;
   localparam int DEF_TICK_HZ      = 1000;
   localparam int DEF_STABLE_TICKS = 20;
   localparam int DEF_LONG_TICKS   = 1000;

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Width able to hold 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic logic released_raw(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Pin-side and control-side signals of the debounce bank.
// The slave modport is the conditioner; the master modport is whatever drives the pins.
interface debounce_bank_if #(parameter int N_CH = 4);
   logic [N_CH-1:0] pb_in;
   logic [N_CH-1:0] pb_level;
   logic [N_CH-1:0] pb_press;
   logic [N_CH-1:0] pb_release;
   logic [N_CH-1:0] pb_long;

   modport master (output pb_in, input pb_level, input pb_press, input pb_release, input pb_long);
   modport slave  (input pb_in, output pb_level, output pb_press, output pb_release, output pb_long);
endinterface

// File: rtl/debounce_bank_tick_gen.sv
// Shared sample-tick prescaler: one-clock tick every DIV clocks, first at DIV clocks after reset.
// Free running, no backpressure.
module debounce_bank_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

   assign tick = (cnt == LAST);
endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: sync, tick-sampled debounce, press/release/long-press pulses.
// Level changes 2 clk + STABLE_TICKS ticks + 1 clk after a clean edge; no backpressure.
module debounce_bank
   import debounce_bank_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int CLK_HZ        = DEF_CLK_HZ,
   parameter int TICK_HZ       = DEF_TICK_HZ,
   parameter int STABLE_TICKS  = DEF_STABLE_TICKS,
   parameter int LONG_TICKS    = DEF_LONG_TICKS,
   parameter int ACTIVE_LOW_IN = 0
) (
   input  logic           clk,
   input  logic           rst,
   debounce_bank_if.slave bus
);
   localparam int   DIV     = calc_div(CLK_HZ, TICK_HZ);
   localparam int   CNT_W   = cnt_width(STABLE_TICKS);
   localparam int   HOLD_W  = cnt_width(LONG_TICKS);
   localparam logic REL_RAW = released_raw(ACTIVE_LOW_IN != 0);

   localparam logic [CNT_W-1:0]  STABLE_C = CNT_W'(STABLE_TICKS);
   localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_TICKS);

   logic            tick;
   logic [N_CH-1:0] level_v;
   logic [N_CH-1:0] press_v;
   logic [N_CH-1:0] release_v;
   logic [N_CH-1:0] long_v;

   debounce_bank_tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [1:0]        sync;
      logic              s;
      logic [CNT_W-1:0]  cnt;
      logic [HOLD_W-1:0] hold;
      logic              level_q;
      logic              press_q;
      logic              release_q;
      logic              long_q;
      logic              differ;
      logic              accept;

      // XOR with the released raw level maps the pin to 1 = pressed.
      assign s      = sync[1] ^ REL_RAW;
      assign differ = tick && (s != level_q);
      assign accept = differ && ((cnt + CNT_W'(1)) == STABLE_C);

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync      <= {2{REL_RAW}};
            cnt       <= '0;
            hold      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            sync      <= {sync[0], bus.pb_in[i]};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            if (tick) begin
               if (!differ) begin
                  cnt <= '0;
               end else if (accept) begin
                  cnt       <= '0;
                  level_q   <= s;
                  press_q   <= s;
                  release_q <= !s;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Suppressed on the releasing tick so long and release never coincide.
            if (!level_q) begin
               hold <= '0;
            end else if (tick && !accept && (hold != LONG_C)) begin
               hold <= hold + HOLD_W'(1);
               if ((hold + HOLD_W'(1)) == LONG_C)
                  long_q <= 1'b1;
            end
         end
      end

      assign level_v[i]   = level_q;
      assign press_v[i]   = press_q;
      assign release_v[i] = release_q;
      assign long_v[i]    = long_q;
   end

   assign bus.pb_level   = level_v;
   assign bus.pb_press   = press_v;
   assign bus.pb_release = release_v;
   assign bus.pb_long    = long_v;
endmodule
